// File: rtl/regfile_param.sv
// Parameterized register file with link/flag destinations and a sequential clear sequencer.
// Optional same-cycle write forwarding to the read ports is enabled by defining REGFILE_BYPASS_EN.
module regfile_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int LINK_REG = 31,
    parameter int FLAG_REG = 30
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write,
    input  logic [1:0]        reg_dst,
    input  logic [2:0]        mem_to_reg,
    input  logic [DATA_W-1:0] data_alu,
    input  logic [DATA_W-1:0] data_dm,
    input  logic [DATA_W-1:0] pc_plus4,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [ADDR_W-1:0] rd,
    output logic [DATA_W-1:0] rs_out,
    output logic [DATA_W-1:0] rt_out,
    input  logic              clr_req,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LINK_IDX = ADDR_W'(LINK_REG);
    localparam logic [ADDR_W-1:0] FLAG_IDX = ADDR_W'(FLAG_REG);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic              clr_start;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              flag_pend;

    logic              accept;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_idx;
    logic [DATA_W-1:0] wr_val;
    logic              flag_set;
    logic              flag_clr;

    assign busy = (state == CLEAR);

    // Write decode: resolves destination index and value for an accepted write.
    always_comb begin
        accept   = reg_write && (state == IDLE);
        wr_en    = 1'b0;
        wr_idx   = '0;
        wr_val   = '0;
        flag_set = 1'b0;
        if (accept) begin
            case (reg_dst)
                2'b00, 2'b01: begin
                    wr_idx = reg_dst[0] ? rd : rt;
                    if (mem_to_reg == 3'b000) begin
                        wr_en  = (wr_idx != '0);
                        wr_val = data_alu;
                    end else if (mem_to_reg == 3'b001) begin
                        wr_en  = (wr_idx != '0);
                        wr_val = data_dm;
                    end
                end
                2'b10: begin
                    wr_idx = LINK_IDX;
                    wr_en  = (LINK_IDX != '0);
                    wr_val = pc_plus4;
                end
                default: begin
                    if (mem_to_reg == 3'b011) begin
                        wr_idx   = FLAG_IDX;
                        wr_en    = (FLAG_IDX != '0);
                        wr_val   = DATA_W'(1);
                        flag_set = (FLAG_IDX != '0);
                    end
                end
            endcase
        end
        // Any accepted write retires a pending flag, even one that stores nothing.
        flag_clr = accept && flag_pend;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        clr_start = 1'b0;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = ADDR_W'(1);
                    clr_start = 1'b1;
                end
            end
            default: begin
                if (cnt == LAST_IDX) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + ADDR_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            flag_pend <= 1'b0;
            state     <= IDLE;
            cnt       <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (flag_clr) begin
                regs[FLAG_IDX] <= '0;
                flag_pend      <= 1'b0;
            end
            // Later assignments win: a new flag write overrides the auto-clear above.
            if (wr_en) regs[wr_idx] <= wr_val;
            if (flag_set) flag_pend <= 1'b1;
            if (clr_start) flag_pend <= 1'b0;
            if (state == CLEAR) regs[cnt] <= '0;
        end
    end

    always_comb begin
        rs_out = (rs == '0) ? '0 : regs[rs];
        rt_out = (rt == '0) ? '0 : regs[rt];
`ifdef REGFILE_BYPASS_EN
        if (rs != '0) begin
            if (wr_en && wr_idx == rs) rs_out = wr_val;
            else if (flag_clr && rs == FLAG_IDX) rs_out = '0;
        end
        if (rt != '0) begin
            if (wr_en && wr_idx == rt) rt_out = wr_val;
            else if (flag_clr && rt == FLAG_IDX) rt_out = '0;
        end
`endif
    end

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench for regfile_param: directed scenarios plus random traffic against an array model.
module tb_regfile_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_write;
    logic [1:0]  reg_dst;
    logic [2:0]  mem_to_reg;
    logic [31:0] data_alu, data_dm, pc_plus4;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_out, rt_out;
    logic        clr_req;
    logic        busy;

    regfile_param dut (
        .clk(clk), .reset(reset), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .data_alu(data_alu), .data_dm(data_dm),
        .pc_plus4(pc_plus4), .rs(rs), .rt(rt), .rd(rd), .rs_out(rs_out),
        .rt_out(rt_out), .clr_req(clr_req), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rs_v;
        logic [31:0] rt_v;
        logic        busy_v;
        int          n;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc_no   = 0;

    // Reference model state
    logic [31:0] m_reg [32];
    bit          m_pend;
    bit          m_busy;
    int          m_cnt;

    task automatic cyc(input logic rw, input logic [1:0] dst, input logic [2:0] m2r,
                       input logic [31:0] alu, input logic [31:0] dm, input logic [31:0] pc,
                       input logic [4:0] a_rs, input logic [4:0] a_rt, input logic [4:0] a_rd,
                       input logic clr, input logic rst, input bit chk);
        logic [31:0] w [32];
        bit   np;
        int   idx;
        exp_t e;
        reg_write = rw; reg_dst = dst; mem_to_reg = m2r;
        data_alu = alu; data_dm = dm; pc_plus4 = pc;
        rs = a_rs; rt = a_rt; rd = a_rd; clr_req = clr; reset = rst;

        for (int i = 0; i < 32; i++) w[i] = m_reg[i];
        np = m_pend;
        if (rw && !m_busy) begin
            if (m_pend) begin w[30] = 32'd0; np = 0; end
            if (dst == 2'd0 || dst == 2'd1) begin
                idx = (dst == 2'd1) ? int'(a_rd) : int'(a_rt);
                if (idx != 0 && m2r == 3'd0) w[idx] = alu;
                if (idx != 0 && m2r == 3'd1) w[idx] = dm;
            end else if (dst == 2'd2) begin
                w[31] = pc;
            end else if (m2r == 3'd3) begin
                w[30] = 32'd1; np = 1;
            end
        end

`ifdef REGFILE_BYPASS_EN
        e.rs_v = (a_rs == 0) ? 32'd0 : w[a_rs];
        e.rt_v = (a_rt == 0) ? 32'd0 : w[a_rt];
`else
        e.rs_v = (a_rs == 0) ? 32'd0 : m_reg[a_rs];
        e.rt_v = (a_rt == 0) ? 32'd0 : m_reg[a_rt];
`endif
        e.busy_v = m_busy;
        e.n      = cyc_no;
        if (chk) sb.push_back(e);

        if (rst) begin
            for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
            m_pend = 0; m_busy = 0; m_cnt = 0;
        end else begin
            for (int i = 0; i < 32; i++) m_reg[i] = w[i];
            m_pend = np;
            if (!m_busy && clr) begin
                m_busy = 1; m_cnt = 1; m_pend = 0;
            end else if (m_busy) begin
                m_reg[m_cnt] = 32'd0;
                if (m_cnt == 31) m_busy = 0;
                else m_cnt++;
            end
        end
        cyc_no++;
        @(posedge clk);
        #1;
    endtask

    task automatic rd2(input logic [4:0] a_rs, input logic [4:0] a_rt);
        cyc(0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, a_rs, a_rt, 5'd0, 0, 0, 1);
    endtask

    task automatic alu_rd(input logic [4:0] a_rd, input logic [31:0] v, input logic [4:0] a_rs);
        cyc(1, 2'd1, 3'd0, v, 32'h0, 32'h0, a_rs, a_rd, a_rd, 0, 0, 1);
    endtask

    // Monitor: outputs are always presented, so one expectation is consumed per cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_checks++;
            if (rs_out !== e.rs_v) begin
                n_fail++;
                $display("FAIL rs_out cyc=%0d rs=%0d got=%h exp=%h", e.n, rs, rs_out, e.rs_v);
            end
            n_checks++;
            if (rt_out !== e.rt_v) begin
                n_fail++;
                $display("FAIL rt_out cyc=%0d rt=%0d got=%h exp=%h", e.n, rt, rt_out, e.rt_v);
            end
            n_checks++;
            if (busy !== e.busy_v) begin
                n_fail++;
                $display("FAIL busy cyc=%0d got=%b exp=%b", e.n, busy, e.busy_v);
            end
        end
    end

    initial begin
        logic [2:0] m2r_tab [4];
        m2r_tab[0] = 3'd0; m2r_tab[1] = 3'd1; m2r_tab[2] = 3'd3; m2r_tab[3] = 3'd5;
        for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
        m_pend = 0; m_busy = 0; m_cnt = 0;

        // Reset, then reset-state reads
        cyc(0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
        cyc(0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 5'd7, 5'd31, 5'd0, 1, 1, 1);
        rd2(5'd30, 5'd1);

        // rd write and index-0 write
        alu_rd(5'd5, 32'hDEADBEEF, 5'd5);
        rd2(5'd5, 5'd0);
        alu_rd(5'd0, 32'h11111111, 5'd0);
        rd2(5'd0, 5'd5);

        // Link write and data_dm to rt
        cyc(1, 2'd2, 3'd6, 32'h1, 32'h2, 32'h00400024, 5'd31, 5'd8, 5'd4, 0, 0, 1);
        cyc(1, 2'd0, 3'd1, 32'hBAD0BAD0, 32'h12345678, 32'h0, 5'd31, 5'd8, 5'd4, 0, 0, 1);
        rd2(5'd31, 5'd8);

        // Flag set, then auto-clear on the next write; back-to-back flag sets
        cyc(1, 2'd3, 3'd3, 32'h0, 32'h0, 32'h0, 5'd30, 5'd9, 5'd0, 0, 0, 1);
        cyc(1, 2'd0, 3'd0, 32'd7, 32'h0, 32'h0, 5'd30, 5'd9, 5'd0, 0, 0, 1);
        rd2(5'd30, 5'd9);
        cyc(1, 2'd3, 3'd3, 32'h0, 32'h0, 32'h0, 5'd30, 5'd30, 5'd0, 0, 0, 1);
        cyc(1, 2'd3, 3'd3, 32'h0, 32'h0, 32'h0, 5'd30, 5'd30, 5'd0, 0, 0, 1);
        rd2(5'd30, 5'd30);
        cyc(1, 2'd3, 3'd2, 32'h0, 32'h0, 32'h0, 5'd30, 5'd30, 5'd0, 0, 0, 1);
        rd2(5'd30, 5'd30);

        // Same-cycle read of a register being written
        alu_rd(5'd3, 32'h000000A5, 5'd3);
        rd2(5'd3, 5'd3);

        // Fill, clear sequence with a dropped write and a ignored second clr_req
        for (int k = 1; k < 32; k++) alu_rd(5'(k), 32'hFFFFFFFF, 5'(k - 1));
        cyc(0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0, 5'd1, 5'd2, 5'd0, 1, 0, 1);
        for (int k = 1; k <= 31; k++) begin
            if (k == 4) cyc(1, 2'd1, 3'd0, 32'h1, 32'h0, 32'h0, 5'd5, 5'd4, 5'd5, 1, 0, 1);
            else cyc(0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0, 5'(k), 5'((k + 1) % 32), 5'd0, 0, 0, 1);
        end
        rd2(5'd5, 5'd31);
        rd2(5'd30, 5'd17);

        // Reset in the middle of a clear
        for (int k = 1; k < 32; k++) alu_rd(5'(k), 32'hFFFFFFFF, 5'(k));
        cyc(0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0, 5'd20, 5'd31, 5'd0, 1, 0, 1);
        for (int k = 1; k < 10; k++) rd2(5'(k), 5'(k + 10));
        cyc(1, 2'd1, 3'd0, 32'h5, 32'h0, 32'h0, 5'd20, 5'd31, 5'd12, 1, 1, 1);
        rd2(5'd20, 5'd31);
        rd2(5'd25, 5'd11);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            logic [31:0] va;
            va = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
            cyc(logic'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                m2r_tab[$urandom_range(0, 3)], va, $urandom, $urandom,
                5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                logic'($urandom_range(0, 59) == 0), logic'($urandom_range(0, 199) == 0), 1);
        end

        // Drain the scoreboard with a bounded wait
        for (int t = 0; t < 5 && sb.size() > 0; t++) @(negedge clk);
        if (sb.size() > 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d exp=0", sb.size());
        end
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
